rename_regfile: RTL and testbench
=================================

# rename_regfile

Parametrised architectural register file with per-register rename status (busy bit + ROB tag) for the Tomasulo back end. It sits between issue and the ROB/RS dispatch path. Commits from the ROB update values and retire rename tags. Each issued instruction reads its two source operands and renames its destination, and the result is delivered through a registered valid/ready output stage. A held output keeps snooping commits, so operands never go stale, and a flush clears all speculative renames.

## Interface
- XLEN, 32: data width
- NREG, 32: architectural register count, power of two ≥ 2
- RB, $clog2(NREG): register index width (derived)
- TW, 3: ROB tag width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  global enable; low freezes all state, issue and commit ignored
- flush_i  in  1  mispredict flush, synchronous
- is_valid_i  in  1  issue request
- is_ready_o  out  1  = en & !flush_i & (!out_valid_o | out_ready_i)
- is_rs1_i, is_rs2_i, is_rd_i  in  RB  source/destination indices
- is_we_i  in  1  instruction writes rd
- is_tag_i  in  TW  ROB tag allocated to this instruction
- cm_valid_i  in  1  ROB commit
- cm_rd_i  in  RB  committed destination
- cm_tag_i  in  TW  committing ROB tag
- cm_data_i  in  XLEN  committed value
- out_valid_o  out  1  operand bundle valid
- out_ready_i  in  1  downstream accepts bundle
- out_vj_o, out_vk_o  out  XLEN  source values (meaningful when not busy)
- out_qj_o, out_qk_o  out  TW  producer tags (meaningful when busy)
- out_bj_o, out_bk_o  out  1  source still pending
- out_tag_o  out  TW  the instruction's own tag, echoed

## Operation
- State arrays: regs[NREG], busy[NREG], tag[NREG]. Index 0 is hardwired: it always reads 0 and not busy, and is never written or renamed.
- Commit is active when en & cm_valid_i & cm_rd_i≠0:
  - regs[cm_rd_i] ← cm_data_i.
  - busy[cm_rd_i] ← 0 only if busy and tag[cm_rd_i]==cm_tag_i. A younger rename is preserved.
- Issue accept is is_valid_i & is_ready_o. Source read for each rs:
  - rs==0 → v=0, b=0, q=0.
  - Else, if a commit is active and cm_rd_i==rs → v=cm_data_i, b=busy[rs] & tag[rs]≠cm_tag_i, q=tag[rs]. This is the commit bypass.
  - Else → v=regs[rs], b=busy[rs], q=tag[rs].
- Rename on accept with is_we_i & is_rd_i≠0: busy[rd] ← 1, tag[rd] ← is_tag_i.
  - Sources are read before the rename, so rs==rd sees the older producer.
  - Rename beats a commit clear on the same register in the same cycle.
- Output stage:
  - On accept: out_valid_o ← 1 and the payload is loaded.
  - Else if out_ready_i: out_valid_o ← 0.
  - While valid & !ready, the payload is held, except for the snoop below.
- Held-output snoop: if out_valid_o & out_bj_o & an active commit with cm_tag_i==out_qj_o, then out_vj_o ← cm_data_i and out_bj_o ← 0. The same rule applies to k.
- Flush (en & flush_i):
  - All busy ← 0 and out_valid_o ← 0.
  - Issue is blocked, since is_ready_o=0.
  - A commit in the same cycle still writes regs.
  - Tags are left as-is (don't-care once not busy).

## Timing
- Reset: all regs, busy and tag are 0. out_valid_o and all out_* payloads are 0.
- Latency: an accepted issue at edge N appears on out_* after edge N, i.e. 1 cycle.
- Throughput: 1 issue/cycle when out_ready_i is held high.
- A commit is visible to a same-cycle issue through the bypass, and to later issues through regs.
- Reset asserted mid-operation clears everything immediately. No partial state survives.
- en low: outputs hold; is_ready_o=0.

## Structure
- Shared package cpu_pkg holds the XLEN/TW defaults and the operand-bundle struct (v, q, b).
- One sub-module, rf_src_read: combinational per-source lookup (x0 / bypass / array), instantiated twice.

## Test plan
- Reset, then issue rs1=3, rs2=0, rd=5, tag=2 → next cycle vj=0, bj=0, vk=0, bk=0. Then issue rs1=5 → bj=1, qj=2.
- Commit rd=5, tag=2, data=0xAB in the same cycle as an issue with rs1=5 → vj=0xAB, bj=0. busy[5] is cleared.
- Rename rd=5→tag 4, then commit rd=5 tag 2, data=7 → regs[5]=7, busy[5] stays 1 with tag 4.
- Hold out_ready_i=0 with bj=1, qj=4; commit tag 4, data=0x55 → out_vj_o=0x55, bj=0 while still valid. is_ready_o=0 throughout.
- Rename r1..r4 busy, then assert flush_i with commit rd=2, data=9 → all busy 0, out_valid_o=0, regs[2]=9.
- Issue rd=0 with is_we_i=1, then commit rd=0 data=5 → reading x0 gives 0 and not busy.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared back-end definitions: default datapath/tag widths and the per-source
// operand bundle (value, producer tag, pending bit) passed from rename to dispatch.
package cpu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int TW_DEF   = 3;

    typedef struct packed {
        logic [XLEN_DEF-1:0] v;
        logic [TW_DEF-1:0]   q;
        logic                b;
    } operand_t;

endpackage

// File: rtl/rename_regfile_if.sv
// Issue / commit / operand-output bundle of the rename register file.
// master drives issue, commit and downstream ready; slave is the register file.
interface rename_regfile_if
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = 32,
    parameter int TW   = TW_DEF
);
    localparam int RB = $clog2(NREG);

    logic            en;
    logic            flush_i;

    logic            is_valid_i;
    logic            is_ready_o;
    logic [RB-1:0]   is_rs1_i;
    logic [RB-1:0]   is_rs2_i;
    logic [RB-1:0]   is_rd_i;
    logic            is_we_i;
    logic [TW-1:0]   is_tag_i;

    logic            cm_valid_i;
    logic [RB-1:0]   cm_rd_i;
    logic [TW-1:0]   cm_tag_i;
    logic [XLEN-1:0] cm_data_i;

    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] out_vj_o;
    logic [XLEN-1:0] out_vk_o;
    logic [TW-1:0]   out_qj_o;
    logic [TW-1:0]   out_qk_o;
    logic            out_bj_o;
    logic            out_bk_o;
    logic [TW-1:0]   out_tag_o;

    modport master (
        output en, flush_i,
        output is_valid_i, is_rs1_i, is_rs2_i, is_rd_i, is_we_i, is_tag_i,
        input  is_ready_o,
        output cm_valid_i, cm_rd_i, cm_tag_i, cm_data_i,
        input  out_valid_o, out_vj_o, out_vk_o, out_qj_o, out_qk_o,
        input  out_bj_o, out_bk_o, out_tag_o,
        output out_ready_i
    );

    modport slave (
        input  en, flush_i,
        input  is_valid_i, is_rs1_i, is_rs2_i, is_rd_i, is_we_i, is_tag_i,
        output is_ready_o,
        input  cm_valid_i, cm_rd_i, cm_tag_i, cm_data_i,
        output out_valid_o, out_vj_o, out_vk_o, out_qj_o, out_qk_o,
        output out_bj_o, out_bk_o, out_tag_o,
        input  out_ready_i
    );

endinterface

// File: rtl/rf_src_read.sv
// Combinational lookup of one source operand: x0, same-cycle commit bypass,
// or the architectural/rename arrays.
module rf_src_read
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = 32,
    parameter int TW   = TW_DEF
) (
    input  logic [$clog2(NREG)-1:0] rs,
    input  logic                    cm_act,
    input  logic [$clog2(NREG)-1:0] cm_rd,
    input  logic [TW-1:0]           cm_tag,
    input  logic [XLEN-1:0]         cm_data,
    input  logic [XLEN-1:0]         regs [NREG],
    input  logic [NREG-1:0]         busy,
    input  logic [TW-1:0]           tags [NREG],
    output logic [XLEN-1:0]         v,
    output logic [TW-1:0]           q,
    output logic                    b
);
    localparam int RB = $clog2(NREG);
    localparam logic [RB-1:0] X0_IDX = {RB{1'b0}};

    // Priority: x0 constant, then the committing value, then stored state.
    always_comb begin
        v = {XLEN{1'b0}};
        q = {TW{1'b0}};
        b = 1'b0;
        if (rs == X0_IDX) begin
            v = {XLEN{1'b0}};
            q = {TW{1'b0}};
            b = 1'b0;
        end else if (cm_act && (cm_rd == rs)) begin
            // Value comes from the commit; only a younger rename keeps it pending.
            v = cm_data;
            q = tags[rs];
            b = busy[rs] && (tags[rs] != cm_tag);
        end else begin
            v = regs[rs];
            q = tags[rs];
            b = busy[rs];
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register busy/ROB-tag rename state,
// commit bypass, flush and a registered, commit-snooping operand output stage.
module rename_regfile
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = 32,
    parameter int TW   = TW_DEF
) (
    input logic             clk,
    input logic             rst,
    rename_regfile_if.slave bus
);
    localparam int RB = $clog2(NREG);
    localparam logic [RB-1:0] X0_IDX = {RB{1'b0}};

    logic [XLEN-1:0] regs_r [NREG];
    logic [NREG-1:0] busy_r;
    logic [TW-1:0]   tag_r  [NREG];

    logic            out_valid_r;
    logic [XLEN-1:0] out_vj_r;
    logic [XLEN-1:0] out_vk_r;
    logic [TW-1:0]   out_qj_r;
    logic [TW-1:0]   out_qk_r;
    logic            out_bj_r;
    logic            out_bk_r;
    logic [TW-1:0]   out_tag_r;

    logic            commit_s;
    logic            flush_s;
    logic            ready_s;
    logic            accept_s;
    logic            rename_s;
    logic [XLEN-1:0] src_vj_s;
    logic [XLEN-1:0] src_vk_s;
    logic [TW-1:0]   src_qj_s;
    logic [TW-1:0]   src_qk_s;
    logic            src_bj_s;
    logic            src_bk_s;

    // Qualified control strobes; x0 commits and renames are discarded here.
    always_comb begin
        commit_s = bus.en && bus.cm_valid_i && (bus.cm_rd_i != X0_IDX);
        flush_s  = bus.en && bus.flush_i;
        ready_s  = bus.en && !bus.flush_i && (!out_valid_r || bus.out_ready_i);
        accept_s = bus.is_valid_i && ready_s;
        rename_s = accept_s && bus.is_we_i && (bus.is_rd_i != X0_IDX);
    end

    rf_src_read #(.XLEN(XLEN), .NREG(NREG), .TW(TW)) u_src_j (
        .rs      (bus.is_rs1_i),
        .cm_act  (commit_s),
        .cm_rd   (bus.cm_rd_i),
        .cm_tag  (bus.cm_tag_i),
        .cm_data (bus.cm_data_i),
        .regs    (regs_r),
        .busy    (busy_r),
        .tags    (tag_r),
        .v       (src_vj_s),
        .q       (src_qj_s),
        .b       (src_bj_s)
    );

    rf_src_read #(.XLEN(XLEN), .NREG(NREG), .TW(TW)) u_src_k (
        .rs      (bus.is_rs2_i),
        .cm_act  (commit_s),
        .cm_rd   (bus.cm_rd_i),
        .cm_tag  (bus.cm_tag_i),
        .cm_data (bus.cm_data_i),
        .regs    (regs_r),
        .busy    (busy_r),
        .tags    (tag_r),
        .v       (src_vk_s),
        .q       (src_qk_s),
        .b       (src_bk_s)
    );

    // Committed values land in the architectural array, flush or not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (commit_s) begin
            regs_r[bus.cm_rd_i] <= bus.cm_data_i;
        end
    end

    // Rename state: commit clears only a matching tag; a same-cycle rename wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= {NREG{1'b0}};
            for (int i = 0; i < NREG; i++) begin
                tag_r[i] <= {TW{1'b0}};
            end
        end else if (flush_s) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            if (commit_s && busy_r[bus.cm_rd_i] && (tag_r[bus.cm_rd_i] == bus.cm_tag_i)) begin
                busy_r[bus.cm_rd_i] <= 1'b0;
            end
            if (rename_s) begin
                busy_r[bus.is_rd_i] <= 1'b1;
                tag_r[bus.is_rd_i]  <= bus.is_tag_i;
            end
        end
    end

    // Output register: load on accept, drain on ready, snoop commits while held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_vj_r    <= {XLEN{1'b0}};
            out_vk_r    <= {XLEN{1'b0}};
            out_qj_r    <= {TW{1'b0}};
            out_qk_r    <= {TW{1'b0}};
            out_bj_r    <= 1'b0;
            out_bk_r    <= 1'b0;
            out_tag_r   <= {TW{1'b0}};
        end else if (flush_s) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_vj_r    <= src_vj_s;
            out_vk_r    <= src_vk_s;
            out_qj_r    <= src_qj_s;
            out_qk_r    <= src_qk_s;
            out_bj_r    <= src_bj_s;
            out_bk_r    <= src_bk_s;
            out_tag_r   <= bus.is_tag_i;
        end else if (bus.en) begin
            if (bus.out_ready_i) begin
                out_valid_r <= 1'b0;
            end else begin
                if (commit_s && out_valid_r && out_bj_r && (out_qj_r == bus.cm_tag_i)) begin
                    out_vj_r <= bus.cm_data_i;
                    out_bj_r <= 1'b0;
                end
                if (commit_s && out_valid_r && out_bk_r && (out_qk_r == bus.cm_tag_i)) begin
                    out_vk_r <= bus.cm_data_i;
                    out_bk_r <= 1'b0;
                end
            end
        end
    end

    assign bus.is_ready_o  = ready_s;
    assign bus.out_valid_o = out_valid_r;
    assign bus.out_vj_o    = out_vj_r;
    assign bus.out_vk_o    = out_vk_r;
    assign bus.out_qj_o    = out_qj_r;
    assign bus.out_qk_o    = out_qk_r;
    assign bus.out_bj_o    = out_bj_r;
    assign bus.out_bk_o    = out_bk_r;
    assign bus.out_tag_o   = out_tag_r;

endmodule

// File: tb/tb_rename_regfile.sv
// Scenario and randomized bench for rename_regfile against an array/bundle
// reference model of the register file's commit, rename and output rules.
module tb_rename_regfile;
    import cpu_pkg::*;

    logic clk;
    logic rst;

    rename_regfile_if #(.XLEN(32), .NREG(32), .TW(3)) bus ();

    rename_regfile #(.XLEN(32), .NREG(32), .TW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic [2:0]  m_tag  [32];
    logic        e_valid;
    operand_t    e_j;
    operand_t    e_k;
    logic [2:0]  e_tag;

    int n_checks;
    int n_fail;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
            m_tag[i]  = 3'd0;
        end
        e_valid = 1'b0;
        e_j     = '0;
        e_k     = '0;
        e_tag   = 3'd0;
    endtask

    task automatic idle();
        bus.en          = 1'b1;
        bus.flush_i     = 1'b0;
        bus.is_valid_i  = 1'b0;
        bus.is_rs1_i    = 5'd0;
        bus.is_rs2_i    = 5'd0;
        bus.is_rd_i     = 5'd0;
        bus.is_we_i     = 1'b0;
        bus.is_tag_i    = 3'd0;
        bus.cm_valid_i  = 1'b0;
        bus.cm_rd_i     = 5'd0;
        bus.cm_tag_i    = 3'd0;
        bus.cm_data_i   = 32'd0;
        bus.out_ready_i = 1'b1;
    endtask

    task automatic issue(input int rs1, input int rs2, input int rd, input logic we, input int tag);
        bus.is_valid_i = 1'b1;
        bus.is_rs1_i   = 5'(rs1);
        bus.is_rs2_i   = 5'(rs2);
        bus.is_rd_i    = 5'(rd);
        bus.is_we_i    = we;
        bus.is_tag_i   = 3'(tag);
    endtask

    task automatic commit(input int rd, input int tag, input logic [31:0] data);
        bus.cm_valid_i = 1'b1;
        bus.cm_rd_i    = 5'(rd);
        bus.cm_tag_i   = 3'(tag);
        bus.cm_data_i  = data;
    endtask

    function automatic logic model_ready();
        return bus.en && !bus.flush_i && (!e_valid || bus.out_ready_i);
    endfunction

    function automatic operand_t model_src(input logic [4:0] rs);
        operand_t o;
        logic     c;
        o = '0;
        c = bus.en && bus.cm_valid_i && (bus.cm_rd_i != 5'd0);
        if (rs != 5'd0) begin
            o.q = m_tag[rs];
            if (c && bus.cm_rd_i == rs) begin
                o.v = bus.cm_data_i;
                o.b = m_busy[rs] && (m_tag[rs] != bus.cm_tag_i);
            end else begin
                o.v = m_regs[rs];
                o.b = m_busy[rs];
            end
        end
        return o;
    endfunction

    // Advance the model by one clock from the current inputs, then the clock itself.
    task automatic tick();
        logic     c, f, acc;
        operand_t sj, sk;
        c   = bus.en && bus.cm_valid_i && (bus.cm_rd_i != 5'd0);
        f   = bus.en && bus.flush_i;
        acc = bus.is_valid_i && model_ready();
        sj  = model_src(bus.is_rs1_i);
        sk  = model_src(bus.is_rs2_i);
        if (c) begin
            m_regs[bus.cm_rd_i] = bus.cm_data_i;
            if (m_busy[bus.cm_rd_i] && m_tag[bus.cm_rd_i] == bus.cm_tag_i) m_busy[bus.cm_rd_i] = 1'b0;
        end
        if (acc && bus.is_we_i && bus.is_rd_i != 5'd0) begin
            m_busy[bus.is_rd_i] = 1'b1;
            m_tag[bus.is_rd_i]  = bus.is_tag_i;
        end
        if (f) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            e_valid = 1'b0;
        end else if (acc) begin
            e_valid = 1'b1;
            e_j     = sj;
            e_k     = sk;
            e_tag   = bus.is_tag_i;
        end else if (bus.en) begin
            if (bus.out_ready_i) begin
                e_valid = 1'b0;
            end else if (e_valid && c) begin
                if (e_j.b && e_j.q == bus.cm_tag_i) begin e_j.v = bus.cm_data_i; e_j.b = 1'b0; end
                if (e_k.b && e_k.q == bus.cm_tag_i) begin e_k.v = bus.cm_data_i; e_k.b = 1'b0; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        model_reset();
        #12;
        n_checks++;
        if (bus.out_valid_o !== 1'b0 || bus.out_vj_o !== 32'd0 || bus.out_vk_o !== 32'd0 || bus.out_qj_o !== 3'd0 ||
            bus.out_qk_o !== 3'd0 || bus.out_bj_o !== 1'b0 || bus.out_bk_o !== 1'b0 || bus.out_tag_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0b vj=%h vk=%h qj=%0d qk=%0d bj=%0b bk=%0b tag=%0d, required all zero",
                     bus.out_valid_o, bus.out_vj_o, bus.out_vk_o, bus.out_qj_o, bus.out_qk_o, bus.out_bj_o, bus.out_bk_o, bus.out_tag_o);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_rename();
        idle(); issue(3, 0, 5, 1'b1, 2); #1;
        n_checks++;
        if (bus.is_ready_o !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %0b need 1", bus.is_ready_o); end
        tick();
        n_checks++;
        if (bus.out_valid_o !== 1'b1 || bus.out_vj_o !== 32'd0 || bus.out_bj_o !== 1'b0 || bus.out_vk_o !== 32'd0 ||
            bus.out_bk_o !== 1'b0 || bus.out_tag_o !== 3'd2) begin
            n_fail++;
            $display("FAIL basic_first: valid=%0b vj=%h bj=%0b vk=%h bk=%0b tag=%0d, need 1/0/0/0/0/2",
                     bus.out_valid_o, bus.out_vj_o, bus.out_bj_o, bus.out_vk_o, bus.out_bk_o, bus.out_tag_o);
        end
        idle(); issue(5, 3, 0, 1'b0, 3); #1;
        tick();
        n_checks++;
        if (bus.out_bj_o !== 1'b1 || bus.out_qj_o !== 3'd2) begin
            n_fail++; $display("FAIL basic_pending: bj=%0b qj=%0d, need bj=1 qj=2", bus.out_bj_o, bus.out_qj_o);
        end
    endtask

    task automatic test_commit_bypass();
        idle(); issue(5, 0, 6, 1'b0, 1); commit(5, 2, 32'h0000_00AB); #1;
        tick();
        n_checks++;
        if (bus.out_vj_o !== 32'h0000_00AB || bus.out_bj_o !== 1'b0) begin
            n_fail++; $display("FAIL bypass_same_cycle: vj=%h bj=%0b, need vj=000000ab bj=0", bus.out_vj_o, bus.out_bj_o);
        end
        idle(); issue(5, 5, 0, 1'b0, 1); #1;
        tick();
        n_checks++;
        if (bus.out_vk_o !== 32'h0000_00AB || bus.out_bk_o !== 1'b0) begin
            n_fail++; $display("FAIL bypass_busy_cleared: vk=%h bk=%0b, need vk=000000ab bk=0", bus.out_vk_o, bus.out_bk_o);
        end
    endtask

    task automatic test_younger_rename();
        idle(); issue(0, 0, 5, 1'b1, 4); #1; tick();
        idle(); commit(5, 2, 32'd7); #1; tick();
        idle(); issue(5, 0, 0, 1'b0, 6); #1; tick();
        n_checks++;
        if (bus.out_vj_o !== 32'd7 || bus.out_bj_o !== 1'b1 || bus.out_qj_o !== 3'd4) begin
            n_fail++; $display("FAIL younger_rename: vj=%h bj=%0b qj=%0d, need vj=7 bj=1 qj=4", bus.out_vj_o, bus.out_bj_o, bus.out_qj_o);
        end
    endtask

    task automatic test_held_snoop();
        idle(); bus.out_ready_i = 1'b0; issue(1, 0, 0, 1'b0, 0); #1;
        n_checks++;
        if (bus.is_ready_o !== 1'b0) begin n_fail++; $display("FAIL hold_ready: got %0b need 0", bus.is_ready_o); end
        tick();
        idle(); bus.out_ready_i = 1'b0; commit(5, 4, 32'h55); #1;
        n_checks++;
        if (bus.is_ready_o !== 1'b0) begin n_fail++; $display("FAIL snoop_ready: got %0b need 0", bus.is_ready_o); end
        tick();
        n_checks++;
        if (bus.out_valid_o !== 1'b1 || bus.out_vj_o !== 32'h55 || bus.out_bj_o !== 1'b0 || bus.out_tag_o !== 3'd6) begin
            n_fail++; $display("FAIL held_snoop: valid=%0b vj=%h bj=%0b tag=%0d, need 1/00000055/0/6",
                               bus.out_valid_o, bus.out_vj_o, bus.out_bj_o, bus.out_tag_o);
        end
        idle(); #1; tick();
        n_checks++;
        if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain: valid=%0b need 0", bus.out_valid_o); end
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 4; r++) begin
            idle(); issue(0, 0, r, 1'b1, r); #1; tick();
        end
        idle(); bus.flush_i = 1'b1; commit(2, 7, 32'd9); issue(1, 2, 6, 1'b1, 5); #1;
        n_checks++;
        if (bus.is_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0b need 0", bus.is_ready_o); end
        tick();
        n_checks++;
        if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: valid=%0b need 0", bus.out_valid_o); end
        idle(); issue(2, 1, 0, 1'b0, 0); #1; tick();
        n_checks++;
        if (bus.out_vj_o !== 32'd9 || bus.out_bj_o !== 1'b0 || bus.out_bk_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_regs: vj=%h bj=%0b bk=%0b, need vj=9 bj=0 bk=0", bus.out_vj_o, bus.out_bj_o, bus.out_bk_o);
        end
        idle(); issue(3, 4, 0, 1'b0, 0); #1; tick();
        n_checks++;
        if (bus.out_bj_o !== 1'b0 || bus.out_bk_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_busy: bj=%0b bk=%0b, need 0/0", bus.out_bj_o, bus.out_bk_o);
        end
    endtask

    task automatic test_x0();
        idle(); issue(0, 0, 0, 1'b1, 5); #1; tick();
        idle(); commit(0, 5, 32'd5); #1; tick();
        idle(); issue(0, 0, 0, 1'b0, 1); #1; tick();
        n_checks++;
        if (bus.out_vj_o !== 32'd0 || bus.out_bj_o !== 1'b0 || bus.out_qj_o !== 3'd0 || bus.out_vk_o !== 32'd0 || bus.out_bk_o !== 1'b0) begin
            n_fail++; $display("FAIL x0_read: vj=%h bj=%0b qj=%0d vk=%h bk=%0b, need all 0",
                               bus.out_vj_o, bus.out_bj_o, bus.out_qj_o, bus.out_vk_o, bus.out_bk_o);
        end
    endtask

    task automatic test_enable_low();
        idle(); issue(2, 0, 7, 1'b1, 3); #1; tick();
        idle(); bus.en = 1'b0; bus.flush_i = 1'b1; issue(1, 1, 8, 1'b1, 1); commit(7, 3, 32'h1234); #1;
        n_checks++;
        if (bus.is_ready_o !== 1'b0) begin n_fail++; $display("FAIL en_low_ready: got %0b need 0", bus.is_ready_o); end
        tick();
        n_checks++;
        if (bus.out_valid_o !== 1'b1 || bus.out_vj_o !== 32'd9 || bus.out_tag_o !== 3'd3) begin
            n_fail++; $display("FAIL en_low_hold: valid=%0b vj=%h tag=%0d, need 1/9/3", bus.out_valid_o, bus.out_vj_o, bus.out_tag_o);
        end
        idle(); issue(7, 8, 0, 1'b0, 2); #1; tick();
        n_checks++;
        if (bus.out_vj_o !== 32'd0 || bus.out_bj_o !== 1'b1 || bus.out_qj_o !== 3'd3 || bus.out_bk_o !== 1'b0) begin
            n_fail++; $display("FAIL en_low_no_effect: vj=%h bj=%0b qj=%0d bk=%0b, need 0/1/3/0",
                               bus.out_vj_o, bus.out_bj_o, bus.out_qj_o, bus.out_bk_o);
        end
    endtask

    task automatic test_random();
        logic [4:0] crd;
        for (int n = 0; n < 400; n++) begin
            idle();
            bus.en          = ($urandom_range(9, 0) != 0);
            bus.flush_i     = ($urandom_range(29, 0) == 0);
            bus.out_ready_i = ($urandom_range(9, 0) < 7);
            if ($urandom_range(3, 0) != 0) issue($urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(7, 0), 1'($urandom_range(1, 0)), $urandom_range(7, 0));
            if ($urandom_range(1, 0) != 0) begin
                crd = 5'($urandom_range(7, 0));
                commit(crd, ($urandom_range(1, 0) != 0) ? int'(m_tag[crd]) : $urandom_range(7, 0), $urandom());
            end
            #1;
            n_checks++;
            if (bus.is_ready_o !== model_ready()) begin
                n_fail++; $display("FAIL rand_ready cyc %0d: got %0b need %0b", n, bus.is_ready_o, model_ready());
            end
            tick();
            n_checks++;
            if (bus.out_valid_o !== e_valid) begin
                n_fail++; $display("FAIL rand_valid cyc %0d: got %0b need %0b", n, bus.out_valid_o, e_valid);
            end
            n_checks++;
            if (bus.out_vj_o !== e_j.v || bus.out_qj_o !== e_j.q || bus.out_bj_o !== e_j.b) begin
                n_fail++; $display("FAIL rand_j cyc %0d: v=%h q=%0d b=%0b need v=%h q=%0d b=%0b",
                                   n, bus.out_vj_o, bus.out_qj_o, bus.out_bj_o, e_j.v, e_j.q, e_j.b);
            end
            n_checks++;
            if (bus.out_vk_o !== e_k.v || bus.out_qk_o !== e_k.q || bus.out_bk_o !== e_k.b) begin
                n_fail++; $display("FAIL rand_k cyc %0d: v=%h q=%0d b=%0b need v=%h q=%0d b=%0b",
                                   n, bus.out_vk_o, bus.out_qk_o, bus.out_bk_o, e_k.v, e_k.q, e_k.b);
            end
            n_checks++;
            if (bus.out_tag_o !== e_tag) begin
                n_fail++; $display("FAIL rand_tag cyc %0d: got %0d need %0d", n, bus.out_tag_o, e_tag);
            end
        end
    endtask

    task automatic test_async_reset();
        idle(); issue(0, 0, 2, 1'b1, 6); commit(5, 1, 32'hDEAD_BEEF); #1; tick();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (bus.out_valid_o !== 1'b0 || bus.out_vj_o !== 32'd0 || bus.out_bj_o !== 1'b0 || bus.out_tag_o !== 3'd0) begin
            n_fail++; $display("FAIL async_reset: valid=%0b vj=%h bj=%0b tag=%0d, need all 0",
                               bus.out_valid_o, bus.out_vj_o, bus.out_bj_o, bus.out_tag_o);
        end
        rst = 1'b1;
        idle(); issue(5, 2, 0, 1'b0, 0); #1; tick();
        n_checks++;
        if (bus.out_vj_o !== 32'd0 || bus.out_bj_o !== 1'b0 || bus.out_vk_o !== 32'd0 || bus.out_bk_o !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_state: vj=%h bj=%0b vk=%h bk=%0b, need all 0",
                               bus.out_vj_o, bus.out_bj_o, bus.out_vk_o, bus.out_bk_o);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_rename();
        test_commit_bypass();
        test_younger_rename();
        test_held_snoop();
        test_flush();
        test_x0();
        test_enable_low();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
